// File: rtl/snn_learning_pkg.sv
// Shared types, widths and helpers for the on-chip STDP learning blocks.
package snn_learning_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POT  = 2'd1,
        DEP  = 2'd2
    } upd_state_t;

    localparam int AGE_W   = 4;
    localparam int AGE_MAX = 15;
    localparam int TD_W    = 5;

    typedef logic signed [TD_W-1:0] td_t;

    // An age of zero means "never spiked", so it never falls inside a window.
    function automatic logic age_in_window(input logic [AGE_W-1:0] age, input int window);
        return (age != '0) && (int'(age) <= window);
    endfunction

endpackage

// File: rtl/stdp_age_tracker.sv
// Saturating spike-age counter: 1 on the spike cycle, counts up to AGE_MAX, 0 until the first spike.
module stdp_age_tracker
    import snn_learning_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             spike,
    output logic [AGE_W-1:0] age
);

    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            age <= '0;
        end else if (spike) begin
            age <= AGE_ONE;
        end else if ((age != '0) && (age != AGE_SAT)) begin
            age <= age + AGE_ONE;
        end
    end

endmodule

// File: rtl/stdp_weight_update_engine.sv
// STDP weight engine for one post-neuron: captures pre/post timing per synapse and sweeps
// the synapse array applying calcium-gated, saturating potentiation and depression.
module stdp_weight_update_engine
    import snn_learning_pkg::*;
#(
    parameter int NUM_SYN = 16,
    parameter int W_WIDTH = 8,
    parameter int W_INIT  = 128,
    parameter int W_MAX   = 255,
    parameter int W_MIN   = 0,
    parameter int DW_POT  = 4,
    parameter int DW_DEP  = 2,
    parameter int WINDOW  = 12
)(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       learn_en,
    input  logic [NUM_SYN-1:0]         pre_spike,
    input  logic                       post_spike,
    input  logic                       calcium_status,
    output td_t                        time_difference,
    output logic [NUM_SYN*W_WIDTH-1:0] weights,
    output logic                       busy,
    output logic                       sweep_done,
    output upd_state_t                 fsm_state
);

    localparam int IDX_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SYN - 1);
    localparam logic [W_WIDTH:0]   POT_STEP = (W_WIDTH + 1)'(DW_POT);
    localparam logic [W_WIDTH:0]   DEP_STEP = (W_WIDTH + 1)'(DW_DEP);
    localparam logic [W_WIDTH:0]   W_MAX_X  = (W_WIDTH + 1)'(W_MAX);
    localparam logic [W_WIDTH:0]   W_MIN_X  = (W_WIDTH + 1)'(W_MIN);
    localparam logic [W_WIDTH-1:0] W_MAX_V  = W_WIDTH'(W_MAX);
    localparam logic [W_WIDTH-1:0] W_MIN_V  = W_WIDTH'(W_MIN);
    localparam logic [W_WIDTH-1:0] W_INIT_V = W_WIDTH'(W_INIT);

    logic [AGE_W-1:0]   pre_age [NUM_SYN];
    logic [AGE_W-1:0]   post_age;

    upd_state_t         state;
    upd_state_t         state_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;

    logic [NUM_SYN-1:0] pot_pend;
    logic [NUM_SYN-1:0] dep_pend;
    logic [NUM_SYN-1:0] pot_pend_n;
    logic [NUM_SYN-1:0] dep_pend_n;
    logic [NUM_SYN-1:0] pot_cap;
    logic [NUM_SYN-1:0] dep_cap;
    logic [AGE_W-1:0]   pot_td [NUM_SYN];
    logic [AGE_W-1:0]   dep_td [NUM_SYN];

    logic [W_WIDTH-1:0] w_q [NUM_SYN];
    logic [W_WIDTH-1:0] w_new;
    logic [W_WIDTH:0]   w_ext;
    logic [W_WIDTH:0]   pot_sum;
    logic [W_WIDTH:0]   dep_diff;
    logic               w_we;

    logic               srv_pend;
    logic [AGE_W-1:0]   srv_td;

    for (genvar g = 0; g < NUM_SYN; g++) begin : g_pre_age
        stdp_age_tracker u_pre_age (
            .clock (clock),
            .reset (reset),
            .spike (pre_spike[g]),
            .age   (pre_age[g])
        );
    end

    stdp_age_tracker u_post_age (
        .clock (clock),
        .reset (reset),
        .spike (post_spike),
        .age   (post_age)
    );

    // Coincident pre and post spikes carry no timing information, so neither direction captures.
    always_comb begin
        pot_cap = '0;
        dep_cap = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            pot_cap[i] = learn_en && post_spike && !pre_spike[i] &&
                         age_in_window(pre_age[i], WINDOW);
            dep_cap[i] = learn_en && pre_spike[i] && !post_spike &&
                         age_in_window(post_age, WINDOW);
        end
    end

    // A fresh capture into the bit under service overrides its clear.
    always_comb begin
        pot_pend_n = pot_pend;
        dep_pend_n = dep_pend;
        for (int i = 0; i < NUM_SYN; i++) begin
            if ((state == POT) && (idx == IDX_W'(i))) pot_pend_n[i] = 1'b0;
            if ((state == DEP) && (idx == IDX_W'(i))) dep_pend_n[i] = 1'b0;
            if (pot_cap[i]) pot_pend_n[i] = 1'b1;
            if (dep_cap[i]) dep_pend_n[i] = 1'b1;
        end
    end

    always_comb begin
        srv_pend        = 1'b0;
        srv_td          = '0;
        time_difference = '0;
        case (state)
            POT: begin
                srv_pend = pot_pend[idx];
                srv_td   = pot_td[idx];
            end
            DEP: begin
                srv_pend = dep_pend[idx];
                srv_td   = dep_td[idx];
            end
            default: ;
        endcase
        if (srv_pend) begin
            time_difference = (state == DEP) ? -td_t'({1'b0, srv_td}) : td_t'({1'b0, srv_td});
        end
    end

    // One extra bit of headroom makes both overflow and underflow visible before clamping.
    always_comb begin
        w_ext    = {1'b0, w_q[idx]};
        pot_sum  = w_ext + POT_STEP;
        dep_diff = w_ext - DEP_STEP;
        w_new    = w_q[idx];
        if (state == POT) begin
            w_new = (pot_sum > W_MAX_X) ? W_MAX_V : pot_sum[W_WIDTH-1:0];
        end else if (state == DEP) begin
            w_new = (dep_diff[W_WIDTH] || (dep_diff < W_MIN_X)) ? W_MIN_V : dep_diff[W_WIDTH-1:0];
        end
        w_we = srv_pend && learn_en && calcium_status;
    end

    // The end of a sweep decides exactly like IDLE does, so back-to-back sweeps have no bubble.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        if ((state == IDLE) || (idx == LAST_IDX)) begin
            idx_n = '0;
            if (|pot_pend_n) begin
                state_n = POT;
            end else if (|dep_pend_n) begin
                state_n = DEP;
            end else begin
                state_n = IDLE;
            end
        end else begin
            idx_n = idx + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            pot_pend   <= '0;
            dep_pend   <= '0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
            for (int i = 0; i < NUM_SYN; i++) begin
                pot_td[i] <= '0;
                dep_td[i] <= '0;
                w_q[i]    <= W_INIT_V;
            end
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            pot_pend   <= pot_pend_n;
            dep_pend   <= dep_pend_n;
            busy       <= (state_n != IDLE);
            sweep_done <= (state_n != IDLE) && (idx_n == LAST_IDX);
            for (int i = 0; i < NUM_SYN; i++) begin
                if (pot_cap[i]) pot_td[i] <= pre_age[i];
                if (dep_cap[i]) dep_td[i] <= post_age;
            end
            if (w_we) w_q[idx] <= w_new;
        end
    end

    always_comb begin
        weights = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            weights[i*W_WIDTH +: W_WIDTH] = w_q[i];
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_stdp_weight_update_engine.sv
// Bench for stdp_weight_update_engine: three instances (weight reset 128, 253, 1) share stimulus
// and are compared every cycle against a spike-timing model, plus directed timing tables.
module tb_stdp_weight_update_engine;
    import snn_learning_pkg::*;

    localparam int N      = 16;
    localparam int WW     = 8;
    localparam int WINDOW = 12;
    localparam int DW_POT = 4;
    localparam int DW_DEP = 2;
    localparam int W_MAX  = 255;
    localparam int W_MIN  = 0;
    localparam int NDUT   = 3;
    localparam int K_NONE = 0;
    localparam int K_POT  = 1;
    localparam int K_DEP  = 2;

    typedef struct {
        int pre_c;
        int pre_syn;
        int post_c;
        int chk;
        int exp_td;
        int exp_busy;
        int exp_w;
    } row_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            learn_en = 1'b1;
    logic [N-1:0]    pre_spike = '0;
    logic            post_spike = 1'b0;
    logic            calcium_status;
    td_t             td_o   [NDUT];
    logic [N*WW-1:0] w_o    [NDUT];
    logic            busy_o [NDUT];
    logic            done_o [NDUT];
    upd_state_t      st_o   [NDUT];

    logic            ca_zero = 1'b0;
    logic            ca_rand = 1'b0;
    logic [31:0]     ca_mask = '1;
    logic [4:0]      ca_sel;
    logic            drv_learn = 1'b1;

    int              n_checks = 0;
    int              n_fail = 0;
    int              watch_syn = -1;
    int              seen_td = 0;
    bit              seen_valid = 0;
    bit              seen_busy = 0;
    logic [N-1:0]    rnd_pre;
    row_t            rows [7];

    int              w_init [NDUT] = '{128, 253, 1};
    int              m_pre_age [N];
    int              m_post_age;
    bit              m_pot_pend [N];
    bit              m_dep_pend [N];
    int              m_pot_td [N];
    int              m_dep_td [N];
    int              m_w [NDUT][N];
    int              m_kind;
    int              m_pos;

    always #5 clock = ~clock;

    // Calcium block stand-in: combinational on time_difference.
    assign ca_sel = 5'(td_o[0]) + 5'd16;
    assign calcium_status = ca_zero ? 1'b0 : (!ca_rand ? 1'b1 : ca_mask[ca_sel]);

    stdp_weight_update_engine #(.W_INIT(128)) u_mid (
        .clock(clock), .reset(reset), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .calcium_status(calcium_status), .time_difference(td_o[0]),
        .weights(w_o[0]), .busy(busy_o[0]), .sweep_done(done_o[0]), .fsm_state(st_o[0])
    );
    stdp_weight_update_engine #(.W_INIT(253)) u_hi (
        .clock(clock), .reset(reset), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .calcium_status(calcium_status), .time_difference(td_o[1]),
        .weights(w_o[1]), .busy(busy_o[1]), .sweep_done(done_o[1]), .fsm_state(st_o[1])
    );
    stdp_weight_update_engine #(.W_INIT(1)) u_lo (
        .clock(clock), .reset(reset), .learn_en(learn_en), .pre_spike(pre_spike),
        .post_spike(post_spike), .calcium_status(calcium_status), .time_difference(td_o[2]),
        .weights(w_o[2]), .busy(busy_o[2]), .sweep_done(done_o[2]), .fsm_state(st_o[2])
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*WW-1:0] act, input logic [N*WW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_pre_age[i]  = 0;
            m_pot_pend[i] = 0;
            m_dep_pend[i] = 0;
            m_pot_td[i]   = 0;
            m_dep_td[i]   = 0;
            for (int d = 0; d < NDUT; d++) m_w[d][i] = w_init[d];
        end
        m_post_age = 0;
        m_kind     = K_NONE;
        m_pos      = 0;
    endfunction

    function automatic int model_td();
        if (m_kind == K_POT && m_pot_pend[m_pos]) return m_pot_td[m_pos];
        if (m_kind == K_DEP && m_dep_pend[m_pos]) return -m_dep_td[m_pos];
        return 0;
    endfunction

    function automatic upd_state_t model_state();
        if (m_kind == K_POT) return POT;
        if (m_kind == K_DEP) return DEP;
        return IDLE;
    endfunction

    function automatic logic [N*WW-1:0] model_flat(input int d);
        logic [N*WW-1:0] f;
        for (int i = 0; i < N; i++) f[i*WW +: WW] = 8'(m_w[d][i]);
        return f;
    endfunction

    function automatic logic [N*WW-1:0] const_flat(input int v);
        logic [N*WW-1:0] f;
        for (int i = 0; i < N; i++) f[i*WW +: WW] = 8'(v);
        return f;
    endfunction

    function automatic int next_age(input int age, input bit spike);
        if (spike) return 1;
        if (age >= 1 && age <= 14) return age + 1;
        return age;
    endfunction

    // Advances the model across one rising edge, from the rules on ages, captures and sweeps.
    function automatic void model_step(input logic [N-1:0] pre, input logic post, input logic learn,
                                       input logic cal, input logic rst);
        bit any_pot;
        bit any_dep;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_kind == K_POT && m_pot_pend[m_pos]) begin
            if (learn && cal)
                for (int d = 0; d < NDUT; d++)
                    m_w[d][m_pos] = (m_w[d][m_pos] + DW_POT > W_MAX) ? W_MAX : m_w[d][m_pos] + DW_POT;
            m_pot_pend[m_pos] = 0;
        end
        if (m_kind == K_DEP && m_dep_pend[m_pos]) begin
            if (learn && cal)
                for (int d = 0; d < NDUT; d++)
                    m_w[d][m_pos] = (m_w[d][m_pos] - DW_DEP < W_MIN) ? W_MIN : m_w[d][m_pos] - DW_DEP;
            m_dep_pend[m_pos] = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (learn && post && !pre[i] && m_pre_age[i] >= 1 && m_pre_age[i] <= WINDOW) begin
                m_pot_pend[i] = 1;
                m_pot_td[i]   = m_pre_age[i];
            end
            if (learn && pre[i] && !post && m_post_age >= 1 && m_post_age <= WINDOW) begin
                m_dep_pend[i] = 1;
                m_dep_td[i]   = m_post_age;
            end
        end
        for (int i = 0; i < N; i++) m_pre_age[i] = next_age(m_pre_age[i], pre[i]);
        m_post_age = next_age(m_post_age, post);
        if (m_kind == K_NONE || m_pos == N - 1) begin
            any_pot = 0;
            any_dep = 0;
            for (int i = 0; i < N; i++) begin
                any_pot |= m_pot_pend[i];
                any_dep |= m_dep_pend[i];
            end
            m_pos  = 0;
            m_kind = any_pot ? K_POT : (any_dep ? K_DEP : K_NONE);
        end else begin
            m_pos++;
        end
    endfunction

    task automatic cycle(input logic [N-1:0] pre, input logic post, input logic rst);
        int         etd;
        logic [4:0] sel;
        logic       cal;
        @(negedge clock);
        pre_spike  = pre;
        post_spike = post;
        reset      = rst;
        learn_en   = drv_learn;
        #1;
        etd = model_td();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("td[%0d]", d), td_o[d], etd);
            check($sformatf("busy[%0d]", d), busy_o[d], (m_kind != K_NONE) ? 1 : 0);
            check($sformatf("sweep_done[%0d]", d), done_o[d], (m_kind != K_NONE && m_pos == N - 1) ? 1 : 0);
            check($sformatf("fsm_state[%0d]", d), st_o[d], model_state());
            check_vec($sformatf("weights[%0d]", d), w_o[d], model_flat(d));
        end
        if (m_kind != K_NONE && m_pos == watch_syn && !seen_valid) begin
            seen_td    = int'(td_o[0]);
            seen_valid = 1;
        end
        if (busy_o[0]) seen_busy = 1;
        sel = 5'(etd + 16);
        cal = ca_zero ? 1'b0 : (!ca_rand ? 1'b1 : ca_mask[sel]);
        model_step(pre, post, drv_learn, cal, rst);
    endtask

    task automatic do_reset();
        cycle('0, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_busy[%0d]", d), busy_o[d], 0);
            check($sformatf("rst_td[%0d]", d), td_o[d], 0);
            check($sformatf("rst_done[%0d]", d), done_o[d], 0);
            check($sformatf("rst_state[%0d]", d), st_o[d], IDLE);
            check_vec($sformatf("rst_weights[%0d]", d), w_o[d], const_flat(w_init[d]));
        end
    endtask

    task automatic pair_event(input int pre_c, input int syn, input int post_c, input int tail);
        logic [N-1:0] one;
        int           last;
        one  = 1;
        last = (pre_c > post_c) ? pre_c : post_c;
        for (int c = 0; c <= last; c++) cycle((c == pre_c) ? (one << syn) : '0, c == post_c, 1'b0);
        repeat (tail) cycle('0, 1'b0, 1'b0);
    endtask

    task automatic wait_pos(input int p, input string name);
        int guard;
        guard = 0;
        while (!(m_kind != K_NONE && m_pos == p) && guard < 40) begin
            cycle('0, 1'b0, 1'b0);
            guard++;
        end
        check(name, (m_kind != K_NONE && m_pos == p) ? 1 : 0, 1);
    endtask

    task automatic clear_watch(input int syn);
        watch_syn  = syn;
        seen_valid = 0;
        seen_busy  = 0;
        seen_td    = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{0, 3, 5, 3, 5, 1, 132};
        rows[1] = '{4, 7, 0, 7, -4, 1, 126};
        rows[2] = '{0, 1, 12, 1, 12, 1, 132};
        rows[3] = '{0, 9, 13, 9, 0, 0, 128};
        rows[4] = '{0, 2, 0, 2, 0, 0, 128};
        rows[5] = '{12, 5, 0, 5, -12, 1, 126};
        rows[6] = '{13, 6, 0, 6, 0, 0, 128};

        model_reset();
        repeat (2) @(posedge clock);
        do_reset();

        for (int r = 0; r < 7; r++) begin
            do_reset();
            clear_watch(rows[r].chk);
            pair_event(rows[r].pre_c, rows[r].pre_syn, rows[r].post_c, 30);
            check($sformatf("row%0d_td", r), seen_td, rows[r].exp_td);
            check($sformatf("row%0d_busy_seen", r), seen_busy, rows[r].exp_busy);
            check($sformatf("row%0d_weight", r), w_o[0][rows[r].chk*WW +: WW], rows[r].exp_w);
            check($sformatf("row%0d_idle", r), busy_o[0], 0);
        end

        do_reset();
        pair_event(0, 0, 3, 25);
        check("sat_hi_first", w_o[1][7:0], 255);
        check("sat_mid_first", w_o[0][7:0], 132);
        pair_event(0, 0, 3, 25);
        check("sat_hi_second", w_o[1][7:0], 255);
        check("sat_mid_second", w_o[0][7:0], 136);
        do_reset();
        pair_event(2, 0, 0, 25);
        check("floor_lo", w_o[2][7:0], 0);
        check("floor_mid", w_o[0][7:0], 126);
        check("floor_hi", w_o[1][7:0], 251);

        do_reset();
        ca_zero = 1'b1;
        clear_watch(3);
        pair_event(0, 3, 5, 30);
        check("ca0_td", seen_td, 5);
        check("ca0_weight", w_o[0][31:24], 128);
        check("ca0_idle", busy_o[0], 0);
        ca_zero = 1'b0;

        do_reset();
        pair_event(0, 3, 5, 0);
        wait_pos(5, "reach_idx5");
        cycle('0, 1'b1, 1'b0);
        wait_pos(15, "reach_idx15");
        cycle('0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("no_gap_busy", busy_o[0], 1);
        check("no_gap_state", st_o[0], POT);
        clear_watch(3);
        wait_pos(8, "reach_idx8");
        check("second_sweep_td", seen_td, 11);
        check("second_sweep_weight", w_o[0][31:24], 136);
        do_reset();

        clear_watch(-1);
        ca_rand = 1'b1;
        ca_mask = $urandom();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) rnd_pre[i] = ($urandom_range(0, 19) == 0);
            drv_learn = ($urandom_range(0, 9) != 0);
            if (c % 150 == 0) ca_mask = $urandom();
            cycle(rnd_pre, $urandom_range(0, 9) == 0, $urandom_range(0, 249) == 0);
        end
        ca_rand   = 1'b0;
        drv_learn = 1'b1;
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
